fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS datapath. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned instruction word into the IF/ID pipeline register for the decode stage. It supports stall, branch/jump redirect with squash, and halts automatically when the program runs off the end of the loaded code, which the memory reports as a run of all-zero words.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, reads combinational imem, and fills IF/ID.
// Handles stall, redirect with squash, misaligned-target trap, and auto-halt on a run of zero words.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'd0,
  parameter int          ZERO_RUN_HALT = 4,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic             halted,
  output logic             fetch_error,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int ZR_W = (ZERO_RUN_HALT > 1) ? $clog2(ZERO_RUN_HALT + 1) : 1;
  localparam logic [ZR_W-1:0] ZR_MAX = ZR_W'(ZERO_RUN_HALT);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [ZR_W-1:0] zrun, zrun_nxt;
  logic            take_redir, bad_redir, accept;

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_redir = 1'b0;
    bad_redir  = 1'b0;
    accept     = 1'b0;
    // Saturating zero-run count as it would stand if this word were accepted
    if (imem_data == 32'd0) zrun_nxt = (zrun == ZR_MAX) ? zrun : zrun + 1'b1;
    else                    zrun_nxt = '0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (redirect) begin
          if (redirect_pc[1:0] != 2'b00) begin
            bad_redir = 1'b1;
            state_nxt = HALT;
          end else begin
            take_redir = 1'b1;
          end
        end else if (!stall) begin
          accept = 1'b1;
          if (ZERO_RUN_HALT != 0 && imem_data == 32'd0 && zrun_nxt == ZR_MAX)
            state_nxt = HALT;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      fetch_error    <= 1'b0;
      fetch_count    <= '0;
      zrun           <= '0;
    end else begin
      if (take_redir) begin
        pc          <= redirect_pc;
        if_id_valid <= 1'b0;
        if_id_instr <= '0;
      end
      if (bad_redir) begin
        fetch_error <= 1'b1;
        if_id_valid <= 1'b0;
      end
      if (accept) begin
        if_id_instr    <= imem_data;
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc + 32'd4;
        if_id_valid    <= 1'b1;
        pc             <= pc + 32'd4;
        zrun           <= zrun_nxt;
        if (~&fetch_count) fetch_count <= fetch_count + 1'b1;
      end
      // Nothing leaves IF/ID once halted
      if (state == HALT) if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a small behavioural model predicts PC/state; accepted fetches are
// queued as expected IF/ID contents and popped when the DUT captures them.
module tb_fetch_unit;

  logic        clk, reset_n, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid, halted, fetch_error;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t sbq[$];

  int          m_state;   // 0 idle, 1 run, 2 halt
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  int          m_zr;
  logic        m_valid, m_err;

  fetch_unit #(.RESET_PC(32'd0), .ZERO_RUN_HALT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_error(fetch_error),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: code up to 0x118, zeros after it, and a 0,0,0,x,0 pattern at 0x200.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0)                           return 32'h8D100200;
    if (a == 32'h4)                           return 32'h8D090300;
    if (a >= 32'h200 && a < 32'h214)          return (a == 32'h20C) ? 32'h12345678 : 32'h0;
    if (a <= 32'h118 || a >= 32'h214)         return {8'h24, a[23:0]};
    return 32'h0;
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0; m_cnt = 16'h0; m_zr = 0; m_valid = 1'b0; m_err = 1'b0;
    sbq.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #7;
    model_reset();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_pc4",   if_id_pc_plus4, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_halt",  32'(halted), 32'h0);
    chk("rst_ferr",  32'(fetch_error), 32'h0);
    chk("rst_cnt",   32'(fetch_count), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock edge: predict with the inputs now applied, then compare 1ns after the edge.
  task automatic step();
    bit acc;
    exp_t e;
    acc = 0;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (redirect) begin
          if (redirect_pc[1:0] != 2'b00) begin m_err = 1'b1; m_valid = 1'b0; m_state = 2; end
          else begin m_pc = redirect_pc; m_valid = 1'b0; end
        end else if (!stall) begin
          sbq.push_back('{instr: mem(m_pc), pc: m_pc});
          acc = 1;
          if (mem(m_pc) == 32'h0) begin if (m_zr < 4) m_zr++; end
          else m_zr = 0;
          m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
          if (m_cnt != 16'hFFFF) m_cnt++;
          if (m_zr == 4) m_state = 2;
        end
      end
      default: m_valid = 1'b0;
    endcase
    @(posedge clk); #1;
    chk("addr",  imem_addr, m_pc);
    chk("valid", 32'(if_id_valid), 32'(m_valid));
    chk("halt",  32'(halted), 32'(m_state == 2));
    chk("ferr",  32'(fetch_error), 32'(m_err));
    chk("cnt",   32'(fetch_count), 32'(m_cnt));
    if (acc) begin
      e = sbq.pop_front();
      chk("sb_instr", if_id_instr, e.instr);
      chk("sb_pc",    if_id_pc, e.pc);
      chk("sb_pc4",   if_id_pc_plus4, e.pc + 32'd4);
    end
  endtask

  initial begin
    do_reset();
    step();                                   // IDLE cycle, no fetch
    chk("idle_valid", 32'(if_id_valid), 32'h0);
    chk("idle_addr", imem_addr, 32'h0);
    step();
    chk("f0_instr", if_id_instr, 32'h8D100200);
    chk("f0_pc", if_id_pc, 32'h0);
    chk("f0_pc4", if_id_pc_plus4, 32'h4);
    chk("f0_valid", 32'(if_id_valid), 32'h1);
    step();
    chk("f1_instr", if_id_instr, 32'h8D090300);
    chk("f1_pc", if_id_pc, 32'h4);
    chk("f1_cnt", 32'(fetch_count), 32'h2);

    repeat (4) step();
    chk("pre_stall_addr", imem_addr, 32'h18);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h18);
      chk("stall_ifpc", if_id_pc, 32'h14);
      chk("stall_cnt", 32'(fetch_count), 32'h6);
    end
    stall = 1'b0;
    step();
    chk("resume_ifpc", if_id_pc, 32'h18);
    chk("resume_cnt", 32'(fetch_count), 32'h7);

    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h2C;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("redir_addr", imem_addr, 32'h2C);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_instr", if_id_instr, 32'h0);
    step();
    chk("redir_ifpc", if_id_pc, 32'h2C);
    chk("redir_valid2", 32'(if_id_valid), 32'h1);

    stall = 1'b1;
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("stall_redir_addr", imem_addr, 32'h80);
    stall = 1'b0;
    step();

    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    repeat (8) step();
    chk("zpat_nohalt", 32'(halted), 32'h0);

    redirect = 1'b1; redirect_pc = 32'h110;
    step();
    redirect = 1'b0;
    repeat (6) step();
    chk("pre_halt", 32'(halted), 32'h0);
    step();
    chk("zhalt_halt", 32'(halted), 32'h1);
    chk("zhalt_valid", 32'(if_id_valid), 32'h1);
    chk("zhalt_ifpc", if_id_pc, 32'h128);
    chk("zhalt_addr", imem_addr, 32'h12C);
    step();
    chk("zhalt_valid2", 32'(if_id_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("zhalt_frozen", imem_addr, 32'h12C);

    // Asynchronous reset mid-run
    do_reset();
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h60;
    step();
    redirect = 1'b0;
    chk("mid_addr", imem_addr, 32'h60);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_addr", imem_addr, 32'h0);
    chk("async_valid", 32'(if_id_valid), 32'h0);
    chk("async_cnt", 32'(fetch_count), 32'h0);
    chk("async_ifpc", if_id_pc, 32'h0);
    do_reset();
    step();
    chk("re_idle_valid", 32'(if_id_valid), 32'h0);
    step();
    chk("re_ifpc", if_id_pc, 32'h0);
    chk("re_cnt", 32'(fetch_count), 32'h1);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h2E;
    step();
    redirect = 1'b0;
    chk("mis_ferr", 32'(fetch_error), 32'h1);
    chk("mis_halt", 32'(halted), 32'h1);
    chk("mis_valid", 32'(if_id_valid), 32'h0);
    chk("mis_addr", imem_addr, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("mis_ignore", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
